l1_maxpool: RTL and testbench
=============================

// Module: l1_maxpool
// PURPOSE
//  Downstream of the cnn layer-1 convolution. Consumes the 14x14 map of 16-channel
//  8-bit convolved pixels (one 128-bit beat per pixel, raster order) and does 2x2
//  stride-2 max pooling, giving a 7x7x16 map (49 beats per frame) for layer 2.
//  Streaming design with one line buffer; no backpressure; 1-cycle output latency.
// PARAMETERS
//  CH     16  channels (lanes) per beat; lane k = bits [k*DW +: DW]
//  DW     8   bits per lane, unsigned (post-ReLU)
//  IN_W   14  input columns per row; must be even
//  IN_H   14  input rows per frame; must be even
// PORTS
//  axi_clk         in   1        clock, all logic on rising edge
//  axi_rst         in   1        asynchronous, active-high reset
//  i_clear         in   1        synchronous frame abort; counters/FSM back to frame start
//  i_data_valid    in   CH       per-lane valid from the conv stage
//  i_convoledData  in   CH*DW    convolved pixel, all lanes
//  o_data_valid    out  1        pooled beat valid (1-cycle pulse per beat)
//  o_pooled_data   out  CH*DW    pooled pixel, lane-wise max of a 2x2 window
//  o_row_done      out  1        pulse with the last pooled beat of each output row
//  o_frame_done    out  1        pulse with the 49th (last) pooled beat of a frame
//  o_err           out  1        sticky: partial-valid beat seen; cleared by reset/i_clear
// BEHAVIOUR
//  - Reset: all outputs 0; col=0, row=0, FSM=S_EVEN, pair reg 0. Line buffer not reset
//    (always written before read). Reset mid-frame discards the partial frame.
//  - Beat accepted only when i_data_valid == all ones. Nonzero but not all-ones: beat
//    dropped, counters not advanced, o_err set. All zeros: idle cycle.
//  - Counters: col 0..IN_W-1, row 0..IN_H-1, advanced per accepted beat; col wraps to 0
//    and row increments at col=IN_W-1; row wraps to 0 after IN_H-1 (next frame, no gap).
//  - FSM: S_EVEN (even row) -> S_ODD at end of row; S_ODD -> S_EVEN at end of row.
//  - Even col (either state): lane values into pair reg.
//  - S_EVEN, odd col: linebuf[col>>1] <= vec_max(pair, in).
//  - S_ODD, odd col: next cycle o_data_valid=1,
//    o_pooled_data = vec_max(linebuf[col>>1], vec_max(pair, in)).
//  - o_row_done with beat for col=IN_W-1 in S_ODD; o_frame_done additionally when
//    row=IN_H-1. Both pulses align exactly with o_data_valid.
//  - o_pooled_data holds last value when o_data_valid=0.
//  - Max is per lane, unsigned compare, no width growth; ties return the equal value.
//  - i_clear together with a valid beat: clear wins, beat dropped, o_err cleared;
//    an output produced by the previous cycle's beat still appears (pipeline reg kept).
//  - i_clear and a partial-valid beat in one cycle: o_err ends 0.
//  - Back-to-back beats every cycle supported; arbitrary idle gaps between beats allowed.
// STRUCTURE
//  - cnn_pkg: CH, DW, L1_OUT_W=14, L1_OUT_H=14, L1_POOL_W=7, L1_POOL_H=7 localparams,
//    FSM state encoding (S_EVEN=1'b0, S_ODD=1'b1).
//  - Sub-module vec_max (combinational, CH lanes of DW bits, lane-wise unsigned max),
//    instantiated three times (pair, row-pair, buffer merge).
//  - Line buffer: IN_W/2 x CH*DW register array, one write and one read per beat.
// TESTING
//  1 Ramp frame: pixel(r,c) all lanes = r*14+c -> 49 beats, beat(i,j) all lanes =
//    (2i+1)*14+2j+1; row_done on beats 7,14,..,49; frame_done on beat 49 only.
//  2 Lane independence: lane k = k at (0,0), lane k = 15-k at (1,1), others 0 ->
//    first pooled beat lane k = max(k,15-k); lanes 0..7 = 15..8, lanes 8..15 = 8..15.
//  3 Gappy input: random 0-5 idle cycles between beats of ramp frame -> identical
//    49 outputs as 1, each exactly 1 cycle after its closing beat.
//  4 Partial valid: i_data_valid=16'h00FF mid-frame -> o_err=1, no counter advance;
//    frame still yields 49 correct beats; i_clear then drops o_err to 0.
//  5 Abort: i_clear after 100 beats, then full ramp frame -> exactly 49 correct beats;
//    repeat with axi_rst asserted mid-frame -> all outputs 0 at once, same result after.
//  6 Two frames back-to-back, values 8'hFF/8'h00 checkerboard -> 98 beats all 8'hFF,
//    two frame_done pulses 49 beats apart.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the CNN datapath.
package cnn_pkg;

  localparam int unsigned CH        = 16;
  localparam int unsigned DW        = 8;
  localparam int unsigned L1_OUT_W  = 14;
  localparam int unsigned L1_OUT_H  = 14;
  localparam int unsigned L1_POOL_W = 7;
  localparam int unsigned L1_POOL_H = 7;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } pool_state_e;

endpackage

// File: rtl/vec_max.sv
// Lane-wise unsigned maximum of two packed vectors (combinational).
module vec_max
  import cnn_pkg::*;
#(
  parameter int unsigned LANES = CH,
  parameter int unsigned LW    = DW
) (
  input  logic [LANES*LW-1:0] a,
  input  logic [LANES*LW-1:0] b,
  output logic [LANES*LW-1:0] max_c
);

  always_comb begin
    max_c = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      max_c[k*LW +: LW] = (a[k*LW +: LW] >= b[k*LW +: LW]) ? a[k*LW +: LW] : b[k*LW +: LW];
    end
  end

endmodule

// File: rtl/l1_maxpool.sv
// Layer-1 2x2 stride-2 max pooling over a raster-ordered pixel stream.
// Horizontal pairs merge in pair_q; even-row pair maxima wait in a half-width line buffer.
module l1_maxpool #(
  parameter int unsigned CH   = cnn_pkg::CH,
  parameter int unsigned DW   = cnn_pkg::DW,
  parameter int unsigned IN_W = cnn_pkg::L1_OUT_W,
  parameter int unsigned IN_H = cnn_pkg::L1_OUT_H
) (
  input  logic             axi_clk,
  input  logic             axi_rst,
  input  logic             i_clear,
  input  logic [CH-1:0]    i_data_valid,
  input  logic [CH*DW-1:0] i_convoledData,
  output logic             o_data_valid,
  output logic [CH*DW-1:0] o_pooled_data,
  output logic             o_row_done,
  output logic             o_frame_done,
  output logic             o_err
);

  localparam int unsigned W    = CH * DW;
  localparam int unsigned CW   = $clog2(IN_W);
  localparam int unsigned RW   = $clog2(IN_H);
  localparam int unsigned HALF = IN_W / 2;
  localparam int unsigned AW   = (HALF > 1) ? $clog2(HALF) : 1;

  cnn_pkg::pool_state_e state_q, state_d;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [W-1:0]  pair_q;
  logic [W-1:0]  lb [HALF];
  logic [AW-1:0] lb_idx_c;
  logic [W-1:0]  lb_rd_c;
  logic [W-1:0]  hmax_c;
  logic [W-1:0]  vmax_c;
  logic [W-1:0]  omax_c;

  logic full_c, partial_c, accept_c, col_last_c, row_last_c;
  logic pair_we_c, lb_we_c, out_fire_c;

  // Only an all-lanes-valid beat is a pixel; a partial one is an error.
  assign full_c     = &i_data_valid;
  assign partial_c  = (|i_data_valid) && !full_c;
  assign accept_c   = full_c && !i_clear;
  assign col_last_c = (col_q == CW'(IN_W - 1));
  assign row_last_c = (row_q == RW'(IN_H - 1));
  assign lb_idx_c   = AW'(col_q >> 1);
  assign lb_rd_c    = lb[lb_idx_c];

  vec_max #(.LANES(CH), .LW(DW)) u_hmax (.a(pair_q),  .b(i_convoledData), .max_c(hmax_c));
  vec_max #(.LANES(CH), .LW(DW)) u_vmax (.a(lb_rd_c), .b(pair_q),         .max_c(vmax_c));
  vec_max #(.LANES(CH), .LW(DW)) u_omax (.a(vmax_c),  .b(i_convoledData), .max_c(omax_c));

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) state_q <= cnn_pkg::S_EVEN;
    else         state_q <= state_d;
  end

  // Row-parity FSM; also decodes what the current beat does.
  always_comb begin
    state_d    = state_q;
    pair_we_c  = 1'b0;
    lb_we_c    = 1'b0;
    out_fire_c = 1'b0;
    if (i_clear) begin
      state_d = cnn_pkg::S_EVEN;
    end else if (accept_c) begin
      if (!col_q[0])                        pair_we_c  = 1'b1;
      else if (state_q == cnn_pkg::S_EVEN)  lb_we_c    = 1'b1;
      else                                  out_fire_c = 1'b1;
      if (col_last_c) begin
        state_d = (state_q == cnn_pkg::S_EVEN) ? cnn_pkg::S_ODD : cnn_pkg::S_EVEN;
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (i_clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept_c) begin
      if (col_last_c) begin
        col_q <= '0;
        row_q <= row_last_c ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst)        pair_q <= '0;
    else if (pair_we_c) pair_q <= i_convoledData;
  end

  // Every slot is written on the even row before the odd row reads it.
  always_ff @(posedge axi_clk) begin
    if (lb_we_c) lb[lb_idx_c] <= hmax_c;
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      o_data_valid  <= 1'b0;
      o_pooled_data <= '0;
      o_row_done    <= 1'b0;
      o_frame_done  <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_data_valid <= out_fire_c;
      o_row_done   <= out_fire_c && col_last_c;
      o_frame_done <= out_fire_c && col_last_c && row_last_c;
      if (out_fire_c) o_pooled_data <= omax_c;
      if (i_clear)        o_err <= 1'b0;
      else if (partial_c) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l1_maxpool.sv
// Directed bench for l1_maxpool: window vectors from a table plus whole-frame sequences.
module tb_l1_maxpool;

  logic         axi_clk;
  logic         axi_rst;
  logic         i_clear;
  logic [15:0]  i_data_valid;
  logic [127:0] i_convoledData;
  logic         o_data_valid;
  logic [127:0] o_pooled_data;
  logic         o_row_done;
  logic         o_frame_done;
  logic         o_err;

  l1_maxpool dut (
    .axi_clk       (axi_clk),
    .axi_rst       (axi_rst),
    .i_clear       (i_clear),
    .i_data_valid  (i_data_valid),
    .i_convoledData(i_convoledData),
    .o_data_valid  (o_data_valid),
    .o_pooled_data (o_pooled_data),
    .o_row_done    (o_row_done),
    .o_frame_done  (o_frame_done),
    .o_err         (o_err)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  typedef struct {
    string        name;
    logic [127:0] p00, p01, p10, p11;
    logic [127:0] exp;
  } vec_t;

  vec_t         tbl [5];
  int           cur;
  int           errors = 0;
  int           checks = 0;
  int           out_cnt, fd_cnt;
  logic         exp_err;
  logic [127:0] hold;

  function automatic logic [127:0] lmax(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[k*8 +: 8] = (a[k*8 +: 8] > b[k*8 +: 8]) ? a[k*8 +: 8] : b[k*8 +: 8];
    return y;
  endfunction

  // kind 0: ramp, kind 1: FF/00 checkerboard, kind 2: table window at (0,0)
  function automatic logic [127:0] pix(input int kind, input int r, input int c);
    logic [127:0] p;
    p = '0;
    case (kind)
      0: p = {16{8'(r * 14 + c)}};
      1: p = (((r + c) % 2) == 0) ? {16{8'hFF}} : '0;
      default: begin
        if (r == 0 && c == 0) p = tbl[cur].p00;
        if (r == 0 && c == 1) p = tbl[cur].p01;
        if (r == 1 && c == 0) p = tbl[cur].p10;
        if (r == 1 && c == 1) p = tbl[cur].p11;
      end
    endcase
    return p;
  endfunction

  // One cycle: present inputs, then check outputs just after the edge.
  task automatic drive(input logic [127:0] d, input logic [15:0] v, input logic clr,
                       input logic ev, input logic [127:0] ed, input logic erd, input logic efd);
    @(negedge axi_clk);
    i_convoledData = d;
    i_data_valid   = v;
    i_clear        = clr;
    @(posedge axi_clk);
    #1;
    if (clr) exp_err = 1'b0;
    else if (v != 16'h0000 && v != 16'hFFFF) exp_err = 1'b1;
    if (ev) hold = ed;
    checks++;
    if ({o_data_valid, o_row_done, o_frame_done, o_err} !== {ev, erd, efd, exp_err}) begin
      errors++;
      $display("FAIL flags {valid,row,frame,err}: got %b%b%b%b required %b%b%b%b at %0t",
               o_data_valid, o_row_done, o_frame_done, o_err, ev, erd, efd, exp_err, $time);
    end
    checks++;
    if (o_pooled_data !== hold) begin
      errors++;
      $display("FAIL pooled_data: got %h required %h at %0t", o_pooled_data, hold, $time);
    end
    if (o_data_valid === 1'b1) out_cnt++;
    if (o_frame_done === 1'b1) fd_cnt++;
    i_data_valid = '0;
    i_clear      = 1'b0;
  endtask

  task automatic idle();
    drive('0, '0, 1'b0, 1'b0, hold, 1'b0, 1'b0);
  endtask

  // Feed nbeats of a frame with optional random gaps and one partial beat.
  task automatic run_frame(input int kind, input int nbeats, input int max_gap, input int partial_at);
    int r, c;
    logic ev, erd, efd;
    logic [127:0] ed;
    for (int idx = 0; idx < nbeats; idx++) begin
      r = idx / 14;
      c = idx % 14;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) idle();
      if (idx == partial_at)
        drive({$urandom, $urandom, $urandom, $urandom}, 16'h00FF, 1'b0, 1'b0, hold, 1'b0, 1'b0);
      ev  = (r % 2 == 1) && (c % 2 == 1);
      erd = ev && (c == 13);
      efd = erd && (r == 13);
      if (!ev)           ed = '0;
      else if (kind == 2) ed = (r == 1 && c == 1) ? tbl[cur].exp : '0;
      else ed = lmax(lmax(pix(kind, r - 1, c - 1), pix(kind, r - 1, c)),
                     lmax(pix(kind, r, c - 1), pix(kind, r, c)));
      drive(pix(kind, r, c), 16'hFFFF, 1'b0, ev, ed, erd, efd);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic do_reset();
    @(negedge axi_clk);
    axi_rst        = 1'b1;
    i_data_valid   = '0;
    i_clear        = 1'b0;
    i_convoledData = '0;
    #1;
    checks++;
    if ({o_data_valid, o_row_done, o_frame_done, o_err, o_pooled_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rd=%b fd=%b err=%b data=%h required all 0",
               o_data_valid, o_row_done, o_frame_done, o_err, o_pooled_data);
    end
    hold    = '0;
    exp_err = 1'b0;
    @(negedge axi_clk);
    axi_rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"lane_indep", 128'h0f0e0d0c0b0a0908_0706050403020100, '0, '0,
               128'h0001020304050607_08090a0b0c0d0e0f, 128'h0f0e0d0c0b0a0908_08090a0b0c0d0e0f};
    tbl[1] = '{"ff_top_right", '0, {16{8'hFF}}, '0, '0, {16{8'hFF}}};
    tbl[2] = '{"all_tie", {16{8'h55}}, {16{8'h55}}, {16{8'h55}}, {16{8'h55}}, {16{8'h55}}};
    tbl[3] = '{"unsigned_cmp", {16{8'h80}}, {16{8'h7F}}, {16{8'h01}}, '0, {16{8'h80}}};
    tbl[4] = '{"mixed_lanes", {8{16'hFF00}}, {8{16'h00FF}}, {16{8'h30}}, {16{8'h10}}, {16{8'hFF}}};

    axi_rst        = 1'b1;
    i_clear        = 1'b0;
    i_data_valid   = '0;
    i_convoledData = '0;
    hold           = '0;
    exp_err        = 1'b0;
    cur            = 0;
    do_reset();
    idle();

    // Window vectors: two rows carrying one 2x2 window, then abort.
    for (int i = 0; i < 5; i++) begin
      cur = i;
      run_frame(2, 28, 0, -1);
      drive('0, '0, 1'b1, 1'b0, hold, 1'b0, 1'b0);
    end

    // Ramp frame back-to-back.
    out_cnt = 0; fd_cnt = 0;
    run_frame(0, 196, 0, -1);
    check_cnt("ramp_beats", out_cnt, 49);
    check_cnt("ramp_frame_done", fd_cnt, 1);

    // Ramp frame with random idle gaps.
    out_cnt = 0; fd_cnt = 0;
    run_frame(0, 196, 5, -1);
    idle();
    check_cnt("gappy_beats", out_cnt, 49);

    // Partial-valid beat mid-frame, then clear drops the error.
    out_cnt = 0;
    run_frame(0, 196, 0, 60);
    check_cnt("partial_beats", out_cnt, 49);
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", o_err);
    end
    drive('0, 16'h00FF, 1'b1, 1'b0, hold, 1'b0, 1'b0);

    // Abort with clear after 100 beats; clear with a valid beat drops it.
    run_frame(0, 100, 0, -1);
    drive(pix(0, 7, 2), 16'hFFFF, 1'b1, 1'b0, hold, 1'b0, 1'b0);
    out_cnt = 0; fd_cnt = 0;
    run_frame(0, 196, 0, -1);
    check_cnt("clear_restart_beats", out_cnt, 49);

    // Abort with reset after 100 beats (error raised first).
    run_frame(0, 100, 0, 50);
    do_reset();
    out_cnt = 0; fd_cnt = 0;
    run_frame(0, 196, 0, -1);
    check_cnt("reset_restart_beats", out_cnt, 49);

    // Two checkerboard frames back-to-back.
    out_cnt = 0; fd_cnt = 0;
    run_frame(1, 196, 0, -1);
    check_cnt("cb_first_frame_beats", out_cnt, 49);
    run_frame(1, 196, 0, -1);
    idle();
    check_cnt("cb_total_beats", out_cnt, 98);
    check_cnt("cb_frame_done", fd_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
